// File: rtl/alu_issue_stage_if.sv
// Issue-port bundle between the ID stage and the ID/EX register (alu_issue_stage).
// The master drives the ID-side inputs; the slave is the issue register producing the ALU operands.
interface alu_issue_stage_if #(
    parameter int NB_DATA      = 32,
    parameter int NB_OPERATION = 4,
    parameter int NB_INSTR     = 32
);
    logic                    i_valid;
    logic                    i_stall;
    logic                    i_flush;
    logic [NB_INSTR-1:0]     i_instr;
    logic [NB_DATA-1:0]      i_rs_data;
    logic [NB_DATA-1:0]      i_rt_data;
    logic                    o_valid;
    logic [NB_OPERATION-1:0] o_op;
    logic [NB_DATA-1:0]      o_data_a;
    logic [NB_DATA-1:0]      o_data_b;
    logic                    o_illegal;

    modport master (
        output i_valid, i_stall, i_flush, i_instr, i_rs_data, i_rt_data,
        input  o_valid, o_op, o_data_a, o_data_b, o_illegal
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_instr, i_rs_data, i_rt_data,
        output o_valid, o_op, o_data_a, o_data_b, o_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes the instruction into an ALU op, selects/extends operands, registers them.
// Optional operand forwarding muxes are enabled by defining ALU_ISSUE_FWD_EN.
module alu_issue_stage #(
    parameter int NB_DATA      = 32,
    parameter int NB_OPERATION = 4,
    parameter int NB_INSTR     = 32,
    parameter int NB_SHAMT     = 5
) (
    input  logic               i_clock,
    input  logic               i_reset,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [1:0]         i_fwd_a_sel,
    input  logic [1:0]         i_fwd_b_sel,
    input  logic [NB_DATA-1:0] i_exmem_data,
    input  logic [NB_DATA-1:0] i_memwb_data,
`endif
    alu_issue_stage_if.slave   bus
);

    localparam logic [NB_OPERATION-1:0] OP_ADD     = 4'b0000;
    localparam logic [NB_OPERATION-1:0] OP_SUB     = 4'b0001;
    localparam logic [NB_OPERATION-1:0] OP_AND     = 4'b0010;
    localparam logic [NB_OPERATION-1:0] OP_OR      = 4'b0011;
    localparam logic [NB_OPERATION-1:0] OP_XOR     = 4'b0100;
    localparam logic [NB_OPERATION-1:0] OP_NOR     = 4'b0101;
    localparam logic [NB_OPERATION-1:0] OP_SRL     = 4'b0110;
    localparam logic [NB_OPERATION-1:0] OP_SLL     = 4'b0111;
    localparam logic [NB_OPERATION-1:0] OP_SRA     = 4'b1000;
    localparam logic [NB_OPERATION-1:0] OP_SLT     = 4'b1010;
    localparam logic [NB_OPERATION-1:0] OP_LUI     = 4'b1011;
    localparam logic [NB_OPERATION-1:0] OP_ILLEGAL = 4'b1111;

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [NB_SHAMT-1:0] shamt;
    logic [15:0]         imm;
    logic [NB_DATA-1:0]  imm_se;
    logic [NB_DATA-1:0]  imm_ze;
    logic [NB_DATA-1:0]  shamt_ze;
    logic [NB_DATA-1:0]  rsv_ze;
    logic [NB_DATA-1:0]  rs_val;
    logic [NB_DATA-1:0]  rt_val;
    logic                unused_fields;

    assign opcode        = bus.i_instr[31:26];
    assign funct         = bus.i_instr[5:0];
    assign shamt         = bus.i_instr[10:6];
    assign imm           = bus.i_instr[15:0];
    // Register specifier fields are resolved upstream; only their data arrives here.
    assign unused_fields = ^bus.i_instr[25:16];

`ifdef ALU_ISSUE_FWD_EN
    always_comb begin
        unique case (i_fwd_a_sel)
            2'b01:   rs_val = i_exmem_data;
            2'b10:   rs_val = i_memwb_data;
            default: rs_val = bus.i_rs_data;
        endcase
        unique case (i_fwd_b_sel)
            2'b01:   rt_val = i_exmem_data;
            2'b10:   rt_val = i_memwb_data;
            default: rt_val = bus.i_rt_data;
        endcase
    end
`else
    assign rs_val = bus.i_rs_data;
    assign rt_val = bus.i_rt_data;
`endif

    assign imm_se   = {{(NB_DATA-16){imm[15]}}, imm};
    assign imm_ze   = {{(NB_DATA-16){1'b0}}, imm};
    assign shamt_ze = {{(NB_DATA-NB_SHAMT){1'b0}}, shamt};
    assign rsv_ze   = {{(NB_DATA-NB_SHAMT){1'b0}}, rs_val[NB_SHAMT-1:0]};

    logic [NB_OPERATION-1:0] dec_op;
    logic [NB_DATA-1:0]      dec_a;
    logic [NB_DATA-1:0]      dec_b;
    logic                    dec_illegal;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        dec_op      = OP_ILLEGAL;
        dec_a       = '0;
        dec_b       = '0;
        dec_illegal = 1'b1;
        unique case (opcode)
            6'b000000: begin
                dec_illegal = 1'b0;
                dec_a       = rs_val;
                dec_b       = rt_val;
                unique case (funct)
                    6'b100000, 6'b100001: dec_op = OP_ADD;
                    6'b100010, 6'b100011: dec_op = OP_SUB;
                    6'b100100:            dec_op = OP_AND;
                    6'b100101:            dec_op = OP_OR;
                    6'b100110:            dec_op = OP_XOR;
                    6'b100111:            dec_op = OP_NOR;
                    6'b101010:            dec_op = OP_SLT;
                    6'b000000: begin dec_op = OP_SLL; dec_a = rt_val; dec_b = shamt_ze; end
                    6'b000010: begin dec_op = OP_SRL; dec_a = rt_val; dec_b = shamt_ze; end
                    6'b000011: begin dec_op = OP_SRA; dec_a = rt_val; dec_b = shamt_ze; end
                    6'b000100: begin dec_op = OP_SLL; dec_a = rt_val; dec_b = rsv_ze;   end
                    6'b000110: begin dec_op = OP_SRL; dec_a = rt_val; dec_b = rsv_ze;   end
                    6'b000111: begin dec_op = OP_SRA; dec_a = rt_val; dec_b = rsv_ze;   end
                    default: begin
                        dec_op      = OP_ILLEGAL;
                        dec_a       = '0;
                        dec_b       = '0;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
                dec_op = OP_ADD; dec_a = rs_val; dec_b = imm_se; dec_illegal = 1'b0;
            end
            6'b001010: begin
                dec_op = OP_SLT; dec_a = rs_val; dec_b = imm_se; dec_illegal = 1'b0;
            end
            6'b001100: begin
                dec_op = OP_AND; dec_a = rs_val; dec_b = imm_ze; dec_illegal = 1'b0;
            end
            6'b001101: begin
                dec_op = OP_OR;  dec_a = rs_val; dec_b = imm_ze; dec_illegal = 1'b0;
            end
            6'b001110: begin
                dec_op = OP_XOR; dec_a = rs_val; dec_b = imm_ze; dec_illegal = 1'b0;
            end
            6'b001111: begin
                dec_op = OP_LUI; dec_a = '0;     dec_b = imm_se; dec_illegal = 1'b0;
            end
            6'b000100, 6'b000101: begin
                dec_op = OP_SUB; dec_a = rs_val; dec_b = rt_val; dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Flush beats stall: a bubble must land even while the downstream stage is holding.
    always_ff @(posedge i_clock or posedge i_reset) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            bus.o_valid   <= 1'b0;
            bus.o_op      <= OP_ADD;
            bus.o_data_a  <= '0;
            bus.o_data_b  <= '0;
            bus.o_illegal <= 1'b0;
        end else if (bus.i_flush) begin
            bus.o_valid   <= 1'b0;
            bus.o_op      <= OP_ADD;
            bus.o_data_a  <= '0;
            bus.o_data_b  <= '0;
            bus.o_illegal <= 1'b0;
        end else if (!bus.i_stall) begin
            bus.o_valid   <= bus.i_valid;
            bus.o_op      <= dec_op;
            bus.o_data_a  <= dec_a;
            bus.o_data_b  <= dec_b;
            bus.o_illegal <= bus.i_valid & dec_illegal;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-computed vectors checked one cycle after issue.
// Exercises forwarding too when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

    logic i_clock = 1'b0;
    logic i_reset = 1'b1;
    int   total   = 0;
    int   bad     = 0;

    alu_issue_stage_if #(.NB_DATA(32), .NB_OPERATION(4), .NB_INSTR(32)) bus ();

`ifdef ALU_ISSUE_FWD_EN
    logic [1:0]  i_fwd_a_sel  = 2'b00;
    logic [1:0]  i_fwd_b_sel  = 2'b00;
    logic [31:0] i_exmem_data = '0;
    logic [31:0] i_memwb_data = '0;
`endif

    alu_issue_stage #(
        .NB_DATA(32), .NB_OPERATION(4), .NB_INSTR(32), .NB_SHAMT(5)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
`ifdef ALU_ISSUE_FWD_EN
        .i_fwd_a_sel  (i_fwd_a_sel),
        .i_fwd_b_sel  (i_fwd_b_sel),
        .i_exmem_data (i_exmem_data),
        .i_memwb_data (i_memwb_data),
`endif
        .bus          (bus)
    );

    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic ill);
        chk({tag, ".valid"},   {31'b0, bus.o_valid},   {31'b0, v});
        chk({tag, ".op"},      {28'b0, bus.o_op},      {28'b0, op});
        chk({tag, ".a"},       bus.o_data_a,           a);
        chk({tag, ".b"},       bus.o_data_b,           b);
        chk({tag, ".illegal"}, {31'b0, bus.o_illegal}, {31'b0, ill});
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] rs,
                         input logic [31:0] rt, input logic valid);
        bus.i_instr   = instr;
        bus.i_rs_data = rs;
        bus.i_rt_data = rt;
        bus.i_valid   = valid;
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        bus.i_valid   = 1'b0;
        bus.i_stall   = 1'b0;
        bus.i_flush   = 1'b0;
        bus.i_instr   = '0;
        bus.i_rs_data = '0;
        bus.i_rt_data = '0;
        repeat (2) @(posedge i_clock);
        #1;
        chk_out("reset", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        i_reset = 1'b0;

        // ADDI r2,r1,-1
        issue(32'h2022FFFF, 32'h00000005, 32'h0000_0009, 1'b1);
        chk_out("addi", 1'b1, 4'h0, 32'h00000005, 32'hFFFFFFFF, 1'b0);

        // Reset mid-cycle must clear without a clock edge.
        #2 i_reset = 1'b1;
        #1 chk_out("async_reset", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        i_reset = 1'b0;

        issue(32'h34008000, 32'h00000001, 32'h0, 1'b1);
        chk_out("ori", 1'b1, 4'h3, 32'h00000001, 32'h00008000, 1'b0);

        issue(32'h00000103, 32'h12345678, 32'h80000000, 1'b1);
        chk_out("sra", 1'b1, 4'h8, 32'h80000000, 32'h00000004, 1'b0);

        issue(32'h00000007, 32'h00000024, 32'h00000011, 1'b1);
        chk_out("srav", 1'b1, 4'h8, 32'h00000011, 32'h00000004, 1'b0);

        issue(32'h00000000, 32'h0000ABCD, 32'h00000077, 1'b1);
        chk_out("sll_zero", 1'b1, 4'h7, 32'h00000077, 32'h00000000, 1'b0);

        issue(32'h00000022, 32'h0000000A, 32'h00000003, 1'b1);
        chk_out("sub", 1'b1, 4'h1, 32'h0000000A, 32'h00000003, 1'b0);

        issue(32'h10000000, 32'h00000021, 32'h00000042, 1'b1);
        chk_out("beq", 1'b1, 4'h1, 32'h00000021, 32'h00000042, 1'b0);

        issue(32'h2800FFFE, 32'h00000013, 32'h0, 1'b1);
        chk_out("slti", 1'b1, 4'hA, 32'h00000013, 32'hFFFFFFFE, 1'b0);

        issue(32'h3000F0F0, 32'hFFFF0000, 32'h0, 1'b1);
        chk_out("andi", 1'b1, 4'h2, 32'hFFFF0000, 32'h0000F0F0, 1'b0);

        issue(32'h3C001234, 32'h0000DEAD, 32'h0, 1'b1);
        chk_out("lui", 1'b1, 4'hB, 32'h00000000, 32'h00001234, 1'b0);

        // Hold for 3 cycles while the ID stage presents something else.
        bus.i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(32'h2022FFFF, 32'h00000005, 32'h0, 1'b1);
            chk_out("stall_hold", 1'b1, 4'hB, 32'h00000000, 32'h00001234, 1'b0);
        end

        bus.i_flush = 1'b1;
        issue(32'h2022FFFF, 32'h00000005, 32'h0, 1'b1);
        chk_out("stall_flush", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        bus.i_stall = 1'b0;
        bus.i_flush = 1'b0;

        issue(32'hFC000000, 32'h00000005, 32'h00000006, 1'b1);
        chk_out("illegal_op", 1'b1, 4'hF, 32'h0, 32'h0, 1'b1);

        issue(32'hFC000000, 32'h00000005, 32'h00000006, 1'b0);
        chk("illegal_novalid.valid",   {31'b0, bus.o_valid},   32'h0);
        chk("illegal_novalid.illegal", {31'b0, bus.o_illegal}, 32'h0);

        issue(32'h0000003F, 32'h00000005, 32'h00000006, 1'b1);
        chk_out("illegal_funct", 1'b1, 4'hF, 32'h0, 32'h0, 1'b1);

        // Flush alone after a live load.
        issue(32'h8C000010, 32'h00001000, 32'h0, 1'b1);
        chk_out("lw", 1'b1, 4'h0, 32'h00001000, 32'h00000010, 1'b0);
        bus.i_flush = 1'b1;
        issue(32'h8C000010, 32'h00001000, 32'h0, 1'b1);
        chk_out("flush", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        bus.i_flush = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
        i_fwd_a_sel  = 2'b01;
        i_fwd_b_sel  = 2'b10;
        i_exmem_data = 32'h000000AA;
        i_memwb_data = 32'h00000055;
        issue(32'h00000020, 32'h00000001, 32'h00000002, 1'b1);
        chk_out("fwd_add", 1'b1, 4'h0, 32'h000000AA, 32'h00000055, 1'b0);

        i_fwd_a_sel = 2'b11;
        i_fwd_b_sel = 2'b01;
        issue(32'h00000103, 32'h00000001, 32'h00000002, 1'b1);
        chk_out("fwd_sra", 1'b1, 4'h8, 32'h000000AA, 32'h00000004, 1'b0);
        i_fwd_a_sel = 2'b00;
        i_fwd_b_sel = 2'b00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
